// File: rtl/output_ram_pkg.sv
// Shared defaults and types for the per-channel output capture RAM.
// The RAM module and its bench both import these.
package output_ram_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 13;

    typedef logic [DATA_W-1:0] word_t;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/output_dual_port_ram.sv
// Simple dual-port synchronous RAM: one write port and one read port on a single clock.
// The read path has latency 1, or latency 2 when OUT_REG adds an output register.
module output_dual_port_ram #(
    parameter int DATA_W  = output_ram_pkg::DATA_W,
    parameter int ADDR_W  = output_ram_pkg::ADDR_W,
    parameter bit OUT_REG = 1'b0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic              rden,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = output_ram_pkg::depth_of(ADDR_W);

    // Zero power-up contents, so unwritten words never read as X.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_W-1:0] rd_stage;
    logic              wr_accept;

    // Writes are ignored while reset is held.
    assign wr_accept = wren && reset_n;

    // NOTE: the array has no reset branch; resetting it would block RAM inference
    // and would also erase captured results that must survive a reset.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem[wraddress] <= data;
        end
    end

    // NOTE: non-blocking assignments mean this read sees the array as it was before
    // this edge, which is what gives read-during-write its old-data behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_stage <= '0;
        end else if (rden) begin
            rd_stage <= mem[rdaddress];
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic [DATA_W-1:0] out_stage;

        // Second stage runs every cycle, independent of rden.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                out_stage <= '0;
            end else begin
                out_stage <= rd_stage;
            end
        end

        assign q = out_stage;
    end else begin : g_no_out_reg
        assign q = rd_stage;
    end

endmodule

// File: tb/tb_output_dual_port_ram.sv
// Randomized scoreboard bench for output_dual_port_ram, driving a latency-1 and a
// latency-2 instance with the same stimulus and checking both against an array model.
module tb_output_dual_port_ram;
    import output_ram_pkg::*;

    localparam int AW    = ADDR_W;
    localparam int DEPTH = depth_of(AW);

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    word_t         data = '0;
    logic [AW-1:0] wraddress = '0;
    logic          wren = 1'b0;
    logic [AW-1:0] rdaddress = '0;
    logic          rden = 1'b0;
    word_t         q_lat1;
    word_t         q_lat2;

    output_dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(AW), .OUT_REG(1'b0)) u_dut_lat1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q_lat1)
    );

    output_dual_port_ram #(.DATA_W(DATA_W), .ADDR_W(AW), .OUT_REG(1'b1)) u_dut_lat2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .data      (data),
        .wraddress (wraddress),
        .wren      (wren),
        .rdaddress (rdaddress),
        .rden      (rden),
        .q         (q_lat2)
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    errors = 0;
    word_t ref_mem [int];
    word_t model_q1 = '0;
    word_t model_q2 = '0;
    word_t exp_lat1 [$];
    word_t exp_lat2 [$];

    function automatic word_t model_read(input int addr);
        return ref_mem.exists(addr) ? ref_mem[addr] : '0;
    endfunction

    task automatic check(input string name, input word_t actual, input word_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // One clock of stimulus; afterwards the expected outputs for this edge are queued.
    task automatic cycle(input bit we, input int wa, input word_t wd, input bit re, input int ra);
        wren      = we;
        wraddress = wa[AW-1:0];
        data      = wd;
        rden      = re;
        rdaddress = ra[AW-1:0];
        @(posedge clock);
        #1;
        if (reset_n) begin
            // Latency-2 output is the latency-1 output delayed by one clock.
            model_q2 = model_q1;
            if (re) model_q1 = model_read(ra);
            if (we) ref_mem[wa] = wd;
        end else begin
            model_q1 = '0;
            model_q2 = '0;
        end
        exp_lat1.push_back(model_q1);
        exp_lat2.push_back(model_q2);
        wren = 1'b0;
        rden = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, 1'b0, 0);
    endtask

    always @(negedge clock) begin
        if (exp_lat1.size() > 0) check("q_lat1", q_lat1, exp_lat1.pop_front());
        if (exp_lat2.size() > 0) check("q_lat2", q_lat2, exp_lat2.pop_front());
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("reset_q_lat1", q_lat1, '0);
        check("reset_q_lat2", q_lat2, '0);
        reset_n = 1'b1;

        // Basic write then read, then hold while rden is low.
        cycle(1'b1, 5, 32'hDEADBEEF, 1'b0, 0);
        cycle(1'b0, 0, '0, 1'b1, 5);
        idle(2);
        cycle(1'b1, 5, 32'h12345678, 1'b0, 0);
        idle(2);
        cycle(1'b0, 0, '0, 1'b1, 5);
        idle(2);

        // Read-during-write to one address returns the old word.
        cycle(1'b1, 9, 32'h11111111, 1'b0, 0);
        cycle(1'b1, 9, 32'h22222222, 1'b1, 9);
        cycle(1'b0, 0, '0, 1'b1, 9);
        idle(2);

        // Boundary addresses and a never-written word.
        cycle(1'b1, 0, 32'hA5A5A5A5, 1'b0, 0);
        cycle(1'b1, DEPTH - 1, 32'h5A5A5A5A, 1'b1, 0);
        cycle(1'b0, 0, '0, 1'b1, DEPTH - 1);
        cycle(1'b0, 0, '0, 1'b1, 100);
        idle(2);

        // Asynchronous reset between edges; contents must survive it.
        cycle(1'b1, 20, 32'hCAFEF00D, 1'b0, 0);
        cycle(1'b0, 0, '0, 1'b1, 20);
        idle(2);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_q_lat1", q_lat1, '0);
        check("async_reset_q_lat2", q_lat2, '0);
        model_q1 = '0;
        model_q2 = '0;
        cycle(1'b1, 20, 32'hBADBAD00, 1'b1, 20);
        reset_n = 1'b1;
        cycle(1'b0, 0, '0, 1'b1, 20);
        idle(2);

        // Latency-2 instance shows the old value for one extra clock.
        cycle(1'b1, 3, 32'h00000042, 1'b0, 0);
        cycle(1'b0, 0, '0, 1'b1, 3);
        idle(2);

        // Random traffic, mostly in a small window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            automatic int    wa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
            automatic int    ra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : int'($urandom_range(0, 15));
            automatic word_t wd = word_t'($urandom);
            cycle(1'(($urandom_range(0, 1))), wa, wd, 1'(($urandom_range(0, 1))), ra);
        end
        idle(3);

        @(negedge clock);
        #1;
        check("scoreboard_drained", word_t'(exp_lat1.size() + exp_lat2.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
